// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: registered carry-lookahead adder/subtractor split into
// STAGES pipeline slices. Each slice uses GROUP-bit lookahead groups chained by
// their group carries. The slice carry is registered between stages, and
// the operand slices above the current stage travel along as a skew.
// Optional feature macro: CLA_OVERFLOW_EN. It adds the registered signed-overflow output V.

module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
`ifdef CLA_OVERFLOW_EN
  output logic             V,
`endif
  output logic             C_OUT
);

  localparam int SLICE = WIDTH / STAGES;

  // Elaboration-time sanity checks on the geometry
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("pipelined_cla_adder: STAGES must be 1..8");
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES");
  end
  if ((SLICE % GROUP) != 0) begin : g_bad_group
    $error("pipelined_cla_adder: WIDTH/STAGES must be a multiple of GROUP");
  end

  // One slice of lookahead: the group generate/propagate is accumulated bit by bit.
  // Every carry inside a group is then G(lo..i) | P(lo..i) & group-carry-in.
  // The group carries chain into the next group. Returns {carry_out, sum}.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    logic [SLICE:0]   c;
    logic [SLICE-1:0] s;
    logic             g_acc;
    logic             p_acc;
    c     = '0;
    c[0]  = cin;
    for (int j = 0; j < SLICE / GROUP; j++) begin
      g_acc = 1'b0;
      p_acc = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        g_acc = (a[j*GROUP+i] & b[j*GROUP+i]) | ((a[j*GROUP+i] | b[j*GROUP+i]) & g_acc);
        p_acc = (a[j*GROUP+i] | b[j*GROUP+i]) & p_acc;
        c[j*GROUP+i+1] = g_acc | (p_acc & c[j*GROUP]);
      end
    end
    s = a ^ b ^ c[SLICE-1:0];
    return {c[SLICE], s};
  endfunction

  // Stage registers (index k = pipeline stage k)
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];

  // Per-stage inputs: stage 0 takes the live beat, stage k takes stage k-1
  logic             src_v [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [SLICE:0]   slice_res;
  logic             adv;

  // The whole pipe advances together whenever the output slot is free or being taken
  always_comb begin
    adv = out_ready | ~valid_q[STAGES-1];
  end

  assign in_ready = adv;

  // Route each stage's source: subtraction is folded in up front as ~B with carry-in 1
  always_comb begin
    src_v[0] = in_valid;
    src_c[0] = SUB | C0;
    src_s[0] = '0;
    src_a[0] = A;
    src_b[0] = SUB ? ~B : B;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src_c[k] = carry_q[k-1];
      src_s[k] = sum_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
    end
  end

  // Stage k adds slice k on top of the partial sum it inherits and passes the operands on
  always_comb begin
    slice_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_res = cla_slice(src_a[k][k*SLICE +: SLICE], src_b[k][k*SLICE +: SLICE], src_c[k]);
      sum_d[k]                   = src_s[k];
      sum_d[k][k*SLICE +: SLICE] = slice_res[SLICE-1:0];
      carry_d[k]                 = slice_res[SLICE];
      a_d[k]                     = src_a[k];
      b_d[k]                     = src_b[k];
      valid_d[k]                 = src_v[k];
    end
  end

`ifdef CLA_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  // Carry into the MSB is recovered as a^b^sum at that bit; overflow is it XOR carry-out
  always_comb begin
    ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
          ^ sum_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];
  end

  // Overflow flag registered alongside the final stage, flushed by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign V = ovf_q;
`endif

  // Pipeline registers: reset flushes every beat, otherwise all stages shift together on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign S         = sum_q[STAGES-1];
  assign C_OUT     = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32, STAGES=2, GROUP=4).
// Expected results come from a behavioural model. They are queued at acceptance
// and compared when the result retires.

module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        C0;
  logic        SUB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        C_OUT;
`ifdef CLA_OVERFLOW_EN
  logic        V;
`endif

  int          errCount   = 0;
  int          checkCount = 0;
  logic [63:0] expQ[$];
  logic [63:0] expVal;
  logic [63:0] gotVal;
  bit          driverDone;

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C0        (C0),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
`ifdef CLA_OVERFLOW_EN
    .V         (V),
`endif
    .C_OUT     (C_OUT)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: packs {V, C_OUT, S}, with V forced to 0 unless the feature is built in
  function automatic logic [63:0] modelResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic c0, input logic sub);
    logic [31:0] be;
    logic [32:0] full;
    logic        ovf;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : c0)};
    ovf  = (a[31] == be[31]) && (full[31] != a[31]);
`ifndef CLA_OVERFLOW_EN
    ovf  = 1'b0;
`endif
    return {30'd0, ovf, full[32], full[31:0]};
  endfunction

  function automatic logic [63:0] observed();
    logic v;
    v = 1'b0;
`ifdef CLA_OVERFLOW_EN
    v = V;
`endif
    return {30'd0, v, C_OUT, S};
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one beat and hold it until accepted; the expectation is queued at acceptance
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic c0, input logic sub);
    bit done;
    done     = 1'b0;
    A        = a;
    B        = b;
    C0       = c0;
    SUB      = sub;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        expQ.push_back(modelResult(a, b, c0, sub));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 100 && expQ.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Output monitor: retiring beats pop the scoreboard, stalled beats must hold the front value
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      gotVal = observed();
      if (expQ.size() == 0) begin
        checkOutput("spurious_out", {63'd0, out_valid}, 64'd0);
      end else if (out_ready) begin
        expVal = expQ.pop_front();
        checkOutput("result", gotVal, expVal);
      end else begin
        checkOutput("stall_hold", gotVal, expQ[0]);
      end
    end
  end

  // Global time bound so the run always ends
  initial begin
    #2000000;
    errCount++;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    C0        = 1'b0;
    SUB       = 1'b0;
    out_ready = 1'b1;

    // Reset for two cycles, then check the idle state
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_S",         {32'd0, S},         64'd0);
    checkOutput("rst_C_OUT",     {63'd0, C_OUT},     64'd0);
    checkOutput("rst_in_ready",  {63'd0, in_ready},  64'd1);
`ifdef CLA_OVERFLOW_EN
    checkOutput("rst_V",         {63'd0, V},         64'd0);
`endif

    // Carry across the slice boundary, with exact latency and a single valid cycle
    $display("[TB] cross-slice carry");
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    in_valid = 1'b0;
    checkOutput("lat_early",      {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    checkOutput("lat_valid",      {63'd0, out_valid}, 64'd1);
    checkOutput("carry_S",        {32'd0, S},         64'd0);
    checkOutput("carry_C_OUT",    {63'd0, C_OUT},     64'd1);
    @(posedge clk); #1;
    checkOutput("lat_one_cycle",  {63'd0, out_valid}, 64'd0);

    // Back-to-back streaming
    $display("[TB] streaming");
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    drain();

    // Backpressure: out_ready low for cycles 3-5 of a 4-beat burst
    $display("[TB] backpressure");
    fork
      begin
        applyStimulus(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32'h0000_0200, 32'h0000_0002, 1'b0, 1'b0);
        applyStimulus(32'h0000_0300, 32'h0000_0003, 1'b0, 1'b0);
        applyStimulus(32'h0000_0400, 32'h0000_0004, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 8; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(negedge clk);
          if (c >= 3 && c <= 5) checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Subtraction and overflow corners
    $display("[TB] subtract");
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    applyStimulus(32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    drain();

    // Random traffic under random backpressure
    $display("[TB] random traffic");
    driverDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          applyStimulus($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
          if ($urandom_range(3) == 0) idleCycles(1);
        end
        in_valid   = 1'b0;
        driverDone = 1'b1;
      end
      begin
        for (int i = 0; i < 2000 && !driverDone; i++) begin
          out_ready = ($urandom_range(2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while a beat is in flight and another is being offered
    $display("[TB] reset mid-flight");
    applyStimulus(32'h0000_0AAA, 32'h0000_0555, 1'b0, 1'b0);
    A        = 32'h0000_0001;
    B        = 32'h0000_0001;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    expQ.delete();
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);

    // Pipe still works after the flush
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
